// File: rtl/fc_err_collector_pkg.sv
// Shared FC package: cell counts, collector state encoding and the error-word clamp.
package fc_err_collector_pkg;

    localparam int FC_FRT_CELL = 32;
    localparam int FC_DATA_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } fc_state_e;

    // Saturate a sign-extended word to [-mag, +mag].
    function automatic int fc_clamp(input int v, input int mag);
        if (v > mag) begin
            return mag;
        end
        if (v < -mag) begin
            return -mag;
        end
        return v;
    endfunction

endpackage

// File: rtl/fc_err_collector_buf.sv
// fc_err_buf: error-word store plus per-entry valid bitmap.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none, the owner decides when to write.
module fc_err_buf #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 16,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_dat,
    output logic              rd_vld
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;

    always_comb begin
        vld_d = vld_q;
        if (clr) begin
            vld_d = '0;
        end
        if (wr_en) begin
            vld_d[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Word storage is left unreset; the bitmap masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];
    assign rd_vld = vld_q[rd_addr];

endmodule

// File: rtl/fc_err_collector.sv
// fc_err_collector: captures one mini batch of FC error words in index order, then streams it out (clamp via FC_ERR_CLIP_EN).
// Latency: first beat one cycle after fc_bck_prop_end, then one beat per accepted cycle.
// Backpressure: err_ready low holds err_valid/err_data/err_idx; the FC side is never stalled.
module fc_err_collector
    import fc_err_collector_pkg::*;
#(
    parameter int                FRT_CELL = FC_FRT_CELL,
    parameter int                DATA_W   = FC_DATA_W,
    parameter logic [DATA_W-1:0] CLIP_MAG = 16'h0400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bck_prop_start,
    input  logic [DATA_W-1:0] fc_err_prop,
    input  logic [15:0]       fc_err_addr,
    input  logic              fc_bck_prop_end,
    output logic              err_valid,
    output logic [DATA_W-1:0] err_data,
    output logic [15:0]       err_idx,
    input  logic              err_ready,
    output logic              err_last,
    output logic              seq_err,
    output logic              busy
);

    localparam int AW = (FRT_CELL > 1) ? $clog2(FRT_CELL) : 1;
    localparam int CW = $clog2(FRT_CELL + 1);

`ifdef FC_ERR_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    fc_state_e         state_q, state_d;
    logic [CW-1:0]     exp_idx_q, exp_idx_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic              seq_err_q, seq_err_d;
    logic              cap_hit;
    logic              wr_en;
    logic              buf_clr;
    logic [DATA_W-1:0] wr_dat;
    logic [DATA_W-1:0] rd_dat;
    logic              rd_vld;

    assign wr_dat = CLIP_EN ? DATA_W'(fc_clamp(int'($signed(fc_err_prop)), int'(CLIP_MAG)))
                            : fc_err_prop;

    always_comb begin
        state_d   = state_q;
        exp_idx_d = exp_idx_q;
        rd_idx_d  = rd_idx_q;
        seq_err_d = seq_err_q;
        wr_en     = 1'b0;
        buf_clr   = 1'b0;
        cap_hit   = (exp_idx_q < CW'(FRT_CELL)) && (fc_err_addr == 16'(exp_idx_q));
        case (state_q)
            ST_IDLE: begin
                if (bck_prop_start) begin
                    state_d   = ST_CAPTURE;
                    exp_idx_d = '0;
                    rd_idx_d  = '0;
                    seq_err_d = 1'b0;
                    buf_clr   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // Indices below exp_idx are repeats of captured words and are dropped silently.
                if (cap_hit) begin
                    wr_en     = 1'b1;
                    exp_idx_d = exp_idx_q + CW'(1);
                end else if ((fc_err_addr > 16'(exp_idx_q)) && (fc_err_addr < 16'(FRT_CELL))) begin
                    seq_err_d = 1'b1;
                end
                if (fc_bck_prop_end) begin
                    state_d  = ST_DRAIN;
                    rd_idx_d = '0;
                    if (exp_idx_d < CW'(FRT_CELL)) begin
                        seq_err_d = 1'b1;
                    end
                end else if (!bck_prop_start) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (err_ready) begin
                    if (rd_idx_q == AW'(FRT_CELL - 1)) begin
                        state_d  = ST_DONE;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!bck_prop_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            exp_idx_q <= '0;
            rd_idx_q  <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_idx_q <= exp_idx_d;
            rd_idx_q  <= rd_idx_d;
            seq_err_q <= seq_err_d;
        end
    end

    fc_err_buf #(
        .DEPTH  (FRT_CELL),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr),
        .wr_en   (wr_en),
        .wr_addr (exp_idx_q[AW-1:0]),
        .wr_dat  (wr_dat),
        .rd_addr (rd_idx_q),
        .rd_dat  (rd_dat),
        .rd_vld  (rd_vld)
    );

    assign err_valid = (state_q == ST_DRAIN);
    assign err_data  = (err_valid && rd_vld) ? rd_dat : '0;
    assign err_idx   = err_valid ? 16'(rd_idx_q) : 16'd0;
    assign err_last  = err_valid && (rd_idx_q == AW'(FRT_CELL - 1));
    assign seq_err   = seq_err_q;
    assign busy      = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);

endmodule
